// File: rtl/dmem_pkg.sv
// Shared types and address helpers for the data-memory responder.
// Combinational helpers only; no latency or flow control of their own.
package dmem_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam int unsigned WORD_BYTES = 4;

    function automatic logic [29:0] word_index(input logic [31:0] addr);
        return 30'(addr / WORD_BYTES);
    endfunction

    // Misaligned or beyond the last word; upper address bits only matter here.
    function automatic logic addr_error(input logic [31:0] addr, input logic [31:0] depth);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word array: synchronous write, synchronous clear on reset, asynchronous read.
// Write lands on the clock edge; read data follows i_raddr combinationally.
module dmem_array #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned AW          = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/dmem_responder.sv
// Data-port responder: one request at a time, WAIT_CYCLES wait states, one-cycle response.
// Response sampled WAIT_CYCLES+1 edges after accept; req_ready only in IDLE, no response backpressure.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_CYCLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_write;
    logic            r_err;
    logic [AW-1:0]   r_idx;
    logic [31:0]     r_wdata;

    logic            w_accept;
    logic            w_enter_resp;
    logic            w_cur_write;
    logic            w_cur_err;
    logic [AW-1:0]   w_cur_idx;
    logic [31:0]     w_cur_wdata;
    logic            w_we;
    logic [31:0]     w_rdata;

    assign w_accept = (r_state == S_IDLE) && req_valid && req_ready;

    // With zero wait states the access happens on the accept edge itself,
    // so the array must be addressed from the live request, not the latches.
    assign w_cur_write = (r_state == S_IDLE) ? req_write : r_write;
    assign w_cur_err   = (r_state == S_IDLE) ? addr_error(req_addr, 32'(DEPTH_WORDS)) : r_err;
    assign w_cur_idx   = (r_state == S_IDLE) ? AW'(word_index(req_addr)) : r_idx;
    assign w_cur_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;

    assign w_enter_resp = ((r_state == S_WAIT) && (r_cnt == CNT_ONE))
                       || ((WAIT_CYCLES == 0) && w_accept);
    assign w_we = w_enter_resp && w_cur_write && !w_cur_err;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_we),
        .i_waddr (w_cur_idx),
        .i_wdata (w_cur_wdata),
        .i_raddr (w_cur_idx),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_write    <= 1'b0;
            r_err      <= 1'b0;
            r_idx      <= '0;
            r_wdata    <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            if (w_enter_resp) begin
                resp_valid <= 1'b1;
                resp_err   <= w_cur_err;
                resp_rdata <= (w_cur_write || w_cur_err) ? 32'h0 : w_rdata;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_write   <= req_write;
                        r_err     <= w_cur_err;
                        r_idx     <= w_cur_idx;
                        r_wdata   <= req_wdata;
                        r_cnt     <= CNT_INIT;
                        req_ready <= 1'b0;
                        r_state   <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - CNT_ONE;
                    if (r_cnt == CNT_ONE) begin
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_state   <= S_IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    r_state   <= S_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: WAIT_CYCLES=2 main instance plus a WAIT_CYCLES=0 instance.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_write, req_ready;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;

    logic        z_req_valid, z_req_write, z_req_ready;
    logic [31:0] z_req_addr, z_req_wdata;
    logic        z_resp_valid, z_resp_err;
    logic [31:0] z_resp_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (z_req_valid),
        .req_ready  (z_req_ready),
        .req_write  (z_req_write),
        .req_addr   (z_req_addr),
        .req_wdata  (z_req_wdata),
        .resp_valid (z_resp_valid),
        .resp_rdata (z_resp_rdata),
        .resp_err   (z_resp_err)
    );

    // Starts on a falling edge with the main DUT idle; ends on a falling edge back in IDLE.
    // lat = edge (counted from the accept edge) at which the response is sampled, -1 on timeout.
    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic [31:0] rd, output logic er);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = -1; rd = 32'hx; er = 1'bx;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = k; rd = resp_rdata; er = resp_err;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        int lat; logic [31:0] rd; logic er;
        reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        z_req_valid = 1'b0; z_req_write = 1'b0; z_req_addr = '0; z_req_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1)   begin n_bad++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        n_cmp++; if (resp_valid !== 1'b0)  begin n_bad++; $display("FAIL reset_valid: got %b want 0", resp_valid); end
        n_cmp++; if (resp_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", resp_rdata); end
        n_cmp++; if (resp_err !== 1'b0)    begin n_bad++; $display("FAIL reset_err: got %b want 0", resp_err); end
        n_cmp++; if (z_req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready_w0: got %b want 1", z_req_ready); end
        reset = 1'b0;
        do_req(1'b0, 32'h0, 32'h0, lat, rd, er);
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL reset_load0: got %h want 0", rd); end
        n_cmp++; if (lat !== 3)    begin n_bad++; $display("FAIL reset_load0_lat: got %0d want 3", lat); end
    endtask

    task automatic test_store_load();
        int lat; logic [31:0] rd; logic er;
        do_req(1'b1, 32'h10, 32'hDEADBEEF, lat, rd, er);
        n_cmp++; if (lat !== 3)                  begin n_bad++; $display("FAIL st10_lat: got %0d want 3", lat); end
        n_cmp++; if ({er, rd} !== {1'b0, 32'h0}) begin n_bad++; $display("FAIL st10_resp: got err=%b rd=%h want err=0 rd=0", er, rd); end
        do_req(1'b0, 32'h10, 32'h0, lat, rd, er);
        n_cmp++; if (lat !== 3)                         begin n_bad++; $display("FAIL ld10_lat: got %0d want 3", lat); end
        n_cmp++; if ({er, rd} !== {1'b0, 32'hDEADBEEF}) begin n_bad++; $display("FAIL ld10_resp: got err=%b rd=%h want err=0 rd=deadbeef", er, rd); end
    endtask

    task automatic test_misaligned();
        int lat; logic [31:0] rd; logic er;
        do_req(1'b1, 32'h12, 32'h1, lat, rd, er);
        n_cmp++; if ({er, rd} !== {1'b1, 32'h0}) begin n_bad++; $display("FAIL st12_err: got err=%b rd=%h want err=1 rd=0", er, rd); end
        do_req(1'b0, 32'h10, 32'h0, lat, rd, er);
        n_cmp++; if ({er, rd} !== {1'b0, 32'hDEADBEEF}) begin n_bad++; $display("FAIL ld10_after_bad_st: got err=%b rd=%h want err=0 rd=deadbeef", er, rd); end
        do_req(1'b0, 32'h11, 32'h0, lat, rd, er);
        n_cmp++; if ({er, rd} !== {1'b1, 32'h0}) begin n_bad++; $display("FAIL ld11_err: got err=%b rd=%h want err=1 rd=0", er, rd); end
    endtask

    task automatic test_range();
        int lat; logic [31:0] rd; logic er;
        do_req(1'b0, 32'h400, 32'h0, lat, rd, er);
        n_cmp++; if ({er, rd} !== {1'b1, 32'h0}) begin n_bad++; $display("FAIL ld400_err: got err=%b rd=%h want err=1 rd=0", er, rd); end
        do_req(1'b1, 32'h400, 32'h12345678, lat, rd, er);
        n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL st400_err: got %b want 1", er); end
        do_req(1'b0, 32'h0, 32'h0, lat, rd, er);
        n_cmp++; if ({er, rd} !== {1'b0, 32'h0}) begin n_bad++; $display("FAIL ld0_no_alias: got err=%b rd=%h want err=0 rd=0", er, rd); end
        do_req(1'b1, 32'h3FC, 32'hCAFEF00D, lat, rd, er);
        n_cmp++; if ({er, rd} !== {1'b0, 32'h0}) begin n_bad++; $display("FAIL st3fc_resp: got err=%b rd=%h want err=0 rd=0", er, rd); end
        do_req(1'b0, 32'h3FC, 32'h0, lat, rd, er);
        n_cmp++; if ({er, rd} !== {1'b0, 32'hCAFEF00D}) begin n_bad++; $display("FAIL ld3fc: got err=%b rd=%h want err=0 rd=cafef00d", er, rd); end
        do_req(1'b0, 32'h8000_0010, 32'h0, lat, rd, er);
        n_cmp++; if ({er, rd} !== {1'b1, 32'h0}) begin n_bad++; $display("FAIL ld_hi_err: got err=%b rd=%h want err=1 rd=0", er, rd); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] rdy_v, rv_v;
        rdy_v = '0; rv_v = '0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_wdata = 32'h0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            rdy_v[k] = req_ready;
            rv_v[k]  = resp_valid;
            if (resp_valid) begin
                n_cmp++;
                if ({resp_err, resp_rdata} !== {1'b0, 32'hDEADBEEF}) begin
                    n_bad++; $display("FAIL b2b_data k=%0d: got err=%b rd=%h want err=0 rd=deadbeef", k, resp_err, resp_rdata);
                end
            end
        end
        req_valid = 1'b0;
        n_cmp++; if (rv_v !== 16'h4444)  begin n_bad++; $display("FAIL b2b_valid_pattern: got %h want 4444", rv_v); end
        n_cmp++; if (rdy_v !== 16'h8888) begin n_bad++; $display("FAIL b2b_ready_pattern: got %h want 8888", rdy_v); end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_wait0();
        logic [7:0] rdy_v, rv_v;
        rdy_v = '0; rv_v = '0;
        z_req_valid = 1'b1; z_req_write = 1'b1; z_req_addr = 32'h8; z_req_wdata = 32'h77;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            rdy_v[k] = z_req_ready;
            rv_v[k]  = z_resp_valid;
            if (z_resp_valid) begin
                n_cmp++;
                if ({z_resp_err, z_resp_rdata} !== {1'b0, (k == 0) ? 32'h0 : 32'h77}) begin
                    n_bad++; $display("FAIL w0_data k=%0d: got err=%b rd=%h", k, z_resp_err, z_resp_rdata);
                end
            end
            if (k == 0) z_req_write = 1'b0;
        end
        z_req_valid = 1'b0;
        n_cmp++; if (rv_v !== 8'h55)  begin n_bad++; $display("FAIL w0_valid_pattern: got %h want 55", rv_v); end
        n_cmp++; if (rdy_v !== 8'hAA) begin n_bad++; $display("FAIL w0_ready_pattern: got %h want aa", rdy_v); end
        @(negedge clk);
    endtask

    task automatic test_reset_in_wait();
        int lat; int seen; logic [31:0] rd; logic er;
        seen = 0;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h55;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_wait_ready: got %b want 1", req_ready); end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL rst_wait_no_resp: got %0d strobes want 0", seen); end
        do_req(1'b0, 32'h20, 32'h0, lat, rd, er);
        n_cmp++; if ({er, rd} !== {1'b0, 32'h0}) begin n_bad++; $display("FAIL rst_wait_ld20: got err=%b rd=%h want err=0 rd=0", er, rd); end
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL rst_wait_ld20_lat: got %0d want 3", lat); end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_misaligned();
        test_range();
        test_back_to_back();
        test_wait0();
        test_reset_in_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
